// File: rtl/hilo_ctrl_pkg.sv
// Shared definitions for the HI/LO sequencer: EX-stage operation codes
// and small decode helpers used by the controller and its testbench.
package hilo_ctrl_pkg;

  localparam logic [2:0] HILO_OP_NONE  = 3'd0;
  localparam logic [2:0] HILO_OP_MULT  = 3'd1;
  localparam logic [2:0] HILO_OP_MULTU = 3'd2;
  localparam logic [2:0] HILO_OP_DIV   = 3'd3;
  localparam logic [2:0] HILO_OP_DIVU  = 3'd4;
  localparam logic [2:0] HILO_OP_MTHI  = 3'd5;
  localparam logic [2:0] HILO_OP_MTLO  = 3'd6;

  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == HILO_OP_MULT) || (op == HILO_OP_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == HILO_OP_DIV) || (op == HILO_OP_DIVU);
  endfunction

endpackage

// File: rtl/hilo_ctrl_mul.sv
// Registered 32x32 multiplier; signed or unsigned, captured only when enabled
// so the product stays stable while the controller counts out the latency.
module hilo_mul
  import hilo_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] product
);

  logic signed [32:0] a_ext;
  logic signed [32:0] b_ext;
  logic signed [65:0] full;

  // A 33-bit signed multiply covers both modes: the extra top bit is the
  // sign for MULT and a forced zero for MULTU.
  assign a_ext = {is_signed & a[31], a};
  assign b_ext = {is_signed & b[31], b};
  assign full  = a_ext * b_ext;

  // Capture the product on accept; hold it until the next accepted multiply.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      product <= '0;
    end else if (en) begin
      product <= full[63:0];
    end
  end

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO register owner: schedules multiply, divide and move-to-HI/LO from EX,
// drives the external divider handshake and stalls the pipe while busy.
module hilo_ctrl
  import hilo_ctrl_pkg::*;
#(
  parameter int MUL_LATENCY = 2,
  parameter int DIV_TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flushE,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        stall_o,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_opa,
  output logic [31:0] div_opb,
  output logic        div_cancel,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic [63:0] hilo_o,
  output logic        busy_o,
  output logic        div_timeout_o
);

  localparam int DIV_CNT_W = $clog2(DIV_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL_WAIT,
    ST_DIV_WAIT
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           mul_cnt_q;
  logic [DIV_CNT_W-1:0] div_cnt_q;
  logic [63:0]          product;

  logic mul_en, mul_signed, mul_done;
  logic div_go, div_done, div_abort, timeout_set;
  logic hi_we, lo_we, timeout_hit;

  // The last permitted DIV_WAIT cycle; the cancel then lands exactly
  // DIV_TIMEOUT cycles after the start pulse.
  assign timeout_hit = (div_cnt_q == DIV_CNT_W'(DIV_TIMEOUT - 1));
  assign busy_o      = (state_q != ST_IDLE);

  hilo_mul u_mul (
    .clk       (clk),
    .rst       (rst),
    .en        (mul_en),
    .is_signed (mul_signed),
    .a         (a),
    .b         (b),
    .product   (product)
  );

  // State register; a mid-operation reset simply drops back to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, stall and per-cycle datapath strobes; flush always wins.
  always_comb begin
    state_d     = state_q;
    stall_o     = 1'b0;
    mul_en      = 1'b0;
    mul_signed  = 1'b0;
    mul_done    = 1'b0;
    div_go      = 1'b0;
    div_done    = 1'b0;
    div_abort   = 1'b0;
    timeout_set = 1'b0;
    hi_we       = 1'b0;
    lo_we       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (op_valid && !flushE) begin
          if (is_mul_op(op)) begin
            mul_en     = 1'b1;
            mul_signed = (op == HILO_OP_MULT);
            stall_o    = 1'b1;
            state_d    = ST_MUL_WAIT;
          end else if (is_div_op(op) && (b != 32'd0)) begin
            div_go  = 1'b1;
            stall_o = 1'b1;
            state_d = ST_DIV_WAIT;
          end else if (op == HILO_OP_MTHI) begin
            hi_we = 1'b1;
          end else if (op == HILO_OP_MTLO) begin
            lo_we = 1'b1;
          end
        end
      end
      ST_MUL_WAIT: begin
        if (flushE) begin
          state_d = ST_IDLE;
        end else if (mul_cnt_q == 3'd0) begin
          mul_done = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          stall_o = 1'b1;
        end
      end
      ST_DIV_WAIT: begin
        if (flushE) begin
          div_abort = 1'b1;
          state_d   = ST_IDLE;
        end else if (div_ready) begin
          div_done = 1'b1;
          state_d  = ST_IDLE;
        end else if (timeout_hit) begin
          div_abort   = 1'b1;
          timeout_set = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          stall_o = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Latency and watchdog counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_cnt_q <= '0;
      div_cnt_q <= '0;
    end else begin
      if (mul_en) begin
        mul_cnt_q <= 3'(MUL_LATENCY - 1);
      end else if (state_q == ST_MUL_WAIT && mul_cnt_q != 3'd0) begin
        mul_cnt_q <= mul_cnt_q - 3'd1;
      end
      if (div_go) begin
        div_cnt_q <= '0;
      end else if (state_q == ST_DIV_WAIT) begin
        div_cnt_q <= div_cnt_q + DIV_CNT_W'(1);
      end
    end
  end

  // Divider handshake: registered pulses and operands held for the whole divide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_start     <= 1'b0;
      div_cancel    <= 1'b0;
      div_signed    <= 1'b0;
      div_opa       <= '0;
      div_opb       <= '0;
      div_timeout_o <= 1'b0;
    end else begin
      div_start     <= div_go;
      div_cancel    <= div_abort;
      div_timeout_o <= div_timeout_o | timeout_set;
      if (div_go) begin
        div_signed <= (op == HILO_OP_DIV);
        div_opa    <= a;
        div_opb    <= b;
      end
    end
  end

  // HI/LO update: completed multiply or divide, or a direct move.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hilo_o <= '0;
    end else if (mul_done) begin
      hilo_o <= product;
    end else if (div_done) begin
      hilo_o <= div_result;
    end else if (hi_we) begin
      hilo_o[63:32] <= a;
    end else if (lo_we) begin
      hilo_o[31:0] <= a;
    end
  end

endmodule
